// File: rtl/collide_spheres_fx.sv
// collide_spheres_fx: fixed-point sphere-sphere contact engine with one shared multiplier and an iterative square root.
// Define COLLIDE_SPHERES_FX_STATS_EN to add saturating test_count / contact_count outputs.
module collide_spheres_fx #(
    parameter int WIDTH   = 32,
    parameter int FRAC    = 16,
    parameter int STATS_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x1,
    input  logic [WIDTH-1:0]     y1,
    input  logic [WIDTH-1:0]     z1,
    input  logic [WIDTH-1:0]     r1,
    input  logic [WIDTH-1:0]     x2,
    input  logic [WIDTH-1:0]     y2,
    input  logic [WIDTH-1:0]     z2,
    input  logic [WIDTH-1:0]     r2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 ret,
    output logic [1:0]           cls,
    output logic [WIDTH:0]       depth,
    output logic [2*WIDTH+3:0]   dist2,
    output logic                 busy
`ifdef COLLIDE_SPHERES_FX_STATS_EN
    ,
    output logic [STATS_W-1:0]   test_count,
    output logic [STATS_W-1:0]   contact_count
`endif
);

    localparam int ACC_W  = 2*WIDTH + 4;
    localparam int MUL_W  = WIDTH + 2;
    localparam int ROOT_W = WIDTH + 2;
    localparam int REM_W  = ROOT_W + 2;
    localparam int CNT_W  = $clog2(ROOT_W);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_DIFF  = 4'd1;
    localparam logic [3:0] S_SQX   = 4'd2;
    localparam logic [3:0] S_SQY   = 4'd3;
    localparam logic [3:0] S_SQZ   = 4'd4;
    localparam logic [3:0] S_CMP   = 4'd5;
    localparam logic [3:0] S_SQRT  = 4'd6;
    localparam logic [3:0] S_DEPTH = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;

    logic [3:0]        state_q, state_d;
    logic [WIDTH-1:0]  x1_q, y1_q, z1_q, r1_q, x2_q, y2_q, z2_q, r2_q;
    logic [WIDTH-1:0]  x1_d, y1_d, z1_d, r1_d, x2_d, y2_d, z2_d, r2_d;
    logic [WIDTH:0]    dx_q, dy_q, dz_q, rsum_q, dx_d, dy_d, dz_d, rsum_d;
    logic [ACC_W-1:0]  rsq_q, acc_q, rad_q, rsq_d, acc_d, rad_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [ROOT_W-1:0] root_q, root_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ret_q, ret_d;
    logic [1:0]        cls_q, cls_d;
    logic [WIDTH:0]    depth_q, depth_d;
    logic [ACC_W-1:0]  dist2_q, dist2_d;

    logic [WIDTH:0]           rsum_w;
    logic signed [MUL_W-1:0]  mul_op;
    logic signed [ACC_W-1:0]  mul_ext;
    logic [ACC_W-1:0]         mul_p;
    logic [REM_W-1:0]         rem_t, trial;
    logic [ROOT_W-1:0]        depth_diff;

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign ret       = ret_q;
    assign cls       = cls_q;
    assign depth     = depth_q;
    assign dist2     = dist2_q;

    // Only one operand is ever live: the multiplier always squares. The radius-sum square
    // is taken in DIFF straight off the registered radii so SQX..SQZ stay free for the deltas.
    always_comb begin
        rsum_w = {1'b0, r1_q} + {1'b0, r2_q};
        case (state_q)
            S_SQX:   mul_op = {dx_q[WIDTH], dx_q};
            S_SQY:   mul_op = {dy_q[WIDTH], dy_q};
            S_SQZ:   mul_op = {dz_q[WIDTH], dz_q};
            default: mul_op = {1'b0, rsum_w};
        endcase
        mul_ext = ACC_W'(mul_op);
        mul_p   = mul_ext * mul_ext;
    end

    always_comb begin
        rem_t      = (rem_q << 2) | REM_W'(rad_q[ACC_W-1 -: 2]);
        trial      = {root_q, 2'b01};
        depth_diff = {1'b0, rsum_q} - root_q;
    end

    always_comb begin
        state_d = state_q;
        x1_d = x1_q; y1_d = y1_q; z1_d = z1_q; r1_d = r1_q;
        x2_d = x2_q; y2_d = y2_q; z2_d = z2_q; r2_d = r2_q;
        dx_d = dx_q; dy_d = dy_q; dz_d = dz_q; rsum_d = rsum_q;
        rsq_d = rsq_q; acc_d = acc_q; rad_d = rad_q;
        rem_d = rem_q; root_d = root_q; cnt_d = cnt_q;
        ret_d = ret_q; cls_d = cls_q; depth_d = depth_q; dist2_d = dist2_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x1_d = x1; y1_d = y1; z1_d = z1; r1_d = r1;
                    x2_d = x2; y2_d = y2; z2_d = z2; r2_d = r2;
                    state_d = S_DIFF;
                end
            end
            S_DIFF: begin
                dx_d    = {x1_q[WIDTH-1], x1_q} - {x2_q[WIDTH-1], x2_q};
                dy_d    = {y1_q[WIDTH-1], y1_q} - {y2_q[WIDTH-1], y2_q};
                dz_d    = {z1_q[WIDTH-1], z1_q} - {z2_q[WIDTH-1], z2_q};
                rsum_d  = rsum_w;
                rsq_d   = mul_p;
                state_d = S_SQX;
            end
            S_SQX: begin
                acc_d   = mul_p;
                state_d = S_SQY;
            end
            S_SQY: begin
                acc_d   = acc_q + mul_p;
                state_d = S_SQZ;
            end
            S_SQZ: begin
                acc_d   = acc_q + mul_p;
                state_d = S_CMP;
            end
            S_CMP: begin
                dist2_d = acc_q;
                if (acc_q > rsq_q) begin
                    ret_d = 1'b0; cls_d = 2'd0; depth_d = '0;
                    state_d = S_DONE;
                end else if (acc_q == '0) begin
                    ret_d = 1'b1; cls_d = 2'd2; depth_d = rsum_q;
                    state_d = S_DONE;
                end else begin
                    rad_d = acc_q; rem_d = '0; root_d = '0; cnt_d = '0;
                    state_d = S_SQRT;
                end
            end
            S_SQRT: begin
                // Restoring square root: two radicand bits in, one root bit out per cycle.
                rad_d = rad_q << 2;
                if (rem_t >= trial) begin
                    rem_d  = rem_t - trial;
                    root_d = {root_q[ROOT_W-2:0], 1'b1};
                end else begin
                    rem_d  = rem_t;
                    root_d = {root_q[ROOT_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ROOT_W-1)) state_d = S_DEPTH;
            end
            S_DEPTH: begin
                ret_d   = 1'b1;
                cls_d   = 2'd1;
                depth_d = depth_diff[ROOT_W-1] ? '0 : depth_diff[WIDTH:0];
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            x1_q <= '0; y1_q <= '0; z1_q <= '0; r1_q <= '0;
            x2_q <= '0; y2_q <= '0; z2_q <= '0; r2_q <= '0;
            dx_q <= '0; dy_q <= '0; dz_q <= '0; rsum_q <= '0;
            rsq_q <= '0; acc_q <= '0; rad_q <= '0;
            rem_q <= '0; root_q <= '0; cnt_q <= '0;
            ret_q <= 1'b0; cls_q <= '0; depth_q <= '0; dist2_q <= '0;
        end else begin
            state_q <= state_d;
            x1_q <= x1_d; y1_q <= y1_d; z1_q <= z1_d; r1_q <= r1_d;
            x2_q <= x2_d; y2_q <= y2_d; z2_q <= z2_d; r2_q <= r2_d;
            dx_q <= dx_d; dy_q <= dy_d; dz_q <= dz_d; rsum_q <= rsum_d;
            rsq_q <= rsq_d; acc_q <= acc_d; rad_q <= rad_d;
            rem_q <= rem_d; root_q <= root_d; cnt_q <= cnt_d;
            ret_q <= ret_d; cls_q <= cls_d; depth_q <= depth_d; dist2_q <= dist2_d;
        end
    end

`ifdef COLLIDE_SPHERES_FX_STATS_EN
    logic [STATS_W-1:0] test_cnt_q, test_cnt_d, contact_cnt_q, contact_cnt_d;
    logic               out_hs;

    always_comb begin
        out_hs        = out_valid & out_ready;
        test_cnt_d    = test_cnt_q;
        contact_cnt_d = contact_cnt_q;
        if (out_hs && test_cnt_q != '1) test_cnt_d = test_cnt_q + 1'b1;
        if (out_hs && ret_q && contact_cnt_q != '1) contact_cnt_d = contact_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            test_cnt_q    <= '0;
            contact_cnt_q <= '0;
        end else begin
            test_cnt_q    <= test_cnt_d;
            contact_cnt_q <= contact_cnt_d;
        end
    end

    assign test_count    = test_cnt_q;
    assign contact_count = contact_cnt_q;
`endif

endmodule

// File: tb/tb_collide_spheres_fx.sv
// Self-checking bench for collide_spheres_fx: directed table, handshake corner cases and random pairs vs. an arithmetic model.
module tb_collide_spheres_fx;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  x1 = '0, y1 = '0, z1 = '0, r1 = '0;
    logic [31:0]  x2 = '0, y2 = '0, z2 = '0, r2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         ret;
    logic [1:0]   cls;
    logic [32:0]  depth;
    logic [67:0]  dist2;
    logic         busy;
`ifdef COLLIDE_SPHERES_FX_STATS_EN
    logic [15:0]  test_count, contact_count;
    int           exp_tests = 0;
    int           exp_contacts = 0;
`endif

    int checks = 0;
    int errors = 0;

    collide_spheres_fx #(.WIDTH(32), .FRAC(16), .STATS_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .y1(y1), .z1(z1), .r1(r1),
        .x2(x2), .y2(y2), .z2(z2), .r2(r2),
        .out_valid(out_valid), .out_ready(out_ready),
        .ret(ret), .cls(cls), .depth(depth), .dist2(dist2), .busy(busy)
`ifdef COLLIDE_SPHERES_FX_STATS_EN
        , .test_count(test_count), .contact_count(contact_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x1, y1, z1, r1, x2, y2, z2, r2;
        logic        ret;
        logic [1:0]  cls;
        logic [32:0] depth;
        logic [67:0] dist2;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input logic [31:0] a1, b1, c1, s1, a2, b2, c2, s2,
                                input logic e_ret, input logic [1:0] e_cls,
                                input logic [32:0] e_depth, input logic [67:0] e_d2, input int e_lat);
        vec_t v;
        v.x1 = a1; v.y1 = b1; v.z1 = c1; v.r1 = s1;
        v.x2 = a2; v.y2 = b2; v.z2 = c2; v.r2 = s2;
        v.ret = e_ret; v.cls = e_cls; v.depth = e_depth; v.dist2 = e_d2; v.lat = e_lat;
        return v;
    endfunction

    // Reference: exact squared distance, greedy bitwise integer sqrt, clamp.
    function automatic vec_t model(input logic [31:0] a1, b1, c1, s1, a2, b2, c2, s2);
        vec_t v;
        logic signed [67:0] dx, dy, dz;
        logic [67:0] d2, rs, rs2, root, cand, dep;
        dx = 68'(signed'(a1)) - 68'(signed'(a2));
        dy = 68'(signed'(b1)) - 68'(signed'(b2));
        dz = 68'(signed'(c1)) - 68'(signed'(c2));
        d2 = dx*dx + dy*dy + dz*dz;
        rs = 68'(s1) + 68'(s2);
        rs2 = rs * rs;
        v = mk(a1, b1, c1, s1, a2, b2, c2, s2, 1'b0, 2'd0, '0, d2, 5);
        if (d2 > rs2) begin
            v.ret = 1'b0; v.cls = 2'd0; v.depth = '0;
        end else if (d2 == 0) begin
            v.ret = 1'b1; v.cls = 2'd2; v.depth = rs[32:0];
        end else begin
            root = '0;
            for (int b = 33; b >= 0; b--) begin
                cand = root | (68'd1 << b);
                if (cand * cand <= d2) root = cand;
            end
            dep = (rs > root) ? rs - root : '0;
            v.ret = 1'b1; v.cls = 2'd1; v.depth = dep[32:0]; v.lat = 40;
        end
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic present(input vec_t v);
        x1 = v.x1; y1 = v.y1; z1 = v.z1; r1 = v.r1;
        x2 = v.x2; y2 = v.y2; z2 = v.z2; r2 = v.r2;
        in_valid = 1'b1;
    endtask

    task automatic wait_valid(input string nm, input int e_lat);
        int lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        chk({nm, ".latency"}, lat, e_lat);
    endtask

    task automatic chk_out(input string nm, input vec_t v);
        chk({nm, ".ret"}, ret, v.ret);
        chk({nm, ".cls"}, cls, v.cls);
        chk({nm, ".depth"}, depth, v.depth);
        chk({nm, ".dist2"}, dist2, v.dist2);
    endtask

    task automatic consume(input string nm, input logic was_contact);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, ".out_valid_drop"}, out_valid, 1'b0);
        chk({nm, ".in_ready_back"}, in_ready, 1'b1);
`ifdef COLLIDE_SPHERES_FX_STATS_EN
        exp_tests++;
        if (was_contact) exp_contacts++;
        chk({nm, ".test_count"}, test_count, exp_tests);
        chk({nm, ".contact_count"}, contact_count, exp_contacts);
`else
        if (was_contact) begin end
`endif
    endtask

    // Called #1 after a clock edge with the engine idle.
    task automatic run_pair(input string nm, input vec_t v, input int hold);
        present(v);
        chk({nm, ".in_ready"}, in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(nm, v.lat);
        repeat (hold) begin @(posedge clk); #1; end
        chk_out(nm, v);
        consume(nm, v.ret);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int bad;
        vec_t v;
        logic [31:0] c[8];

        vecs[0] = mk(32'h0, 32'h0, 32'h0, 32'h10000, 32'h30000, 32'h0, 32'h0, 32'h10000,
                     1'b0, 2'd0, 33'h0, 68'h9_0000_0000, 5);
        vecs[1] = mk(32'h0, 32'h0, 32'h0, 32'h10000, 32'h18000, 32'h0, 32'h0, 32'h10000,
                     1'b1, 2'd1, 33'h8000, 68'h2_4000_0000, 40);
        vecs[2] = mk(32'h50000, 32'hFFFE0000, 32'h70000, 32'h8000, 32'h50000, 32'hFFFE0000, 32'h70000, 32'h4000,
                     1'b1, 2'd2, 33'hC000, 68'h0, 5);
        vecs[3] = mk(32'hFFFF0000, 32'h0, 32'h0, 32'h10000, 32'h10000, 32'h0, 32'h0, 32'h10000,
                     1'b1, 2'd1, 33'h0, 68'h4_0000_0000, 40);
        vecs[4] = mk(32'h0, 32'h40000, 32'h0, 32'h30000, 32'h0, 32'h0, 32'h30000, 32'h30000,
                     1'b1, 2'd1, 33'h10000, 68'h19_0000_0000, 40);
        vecs[5] = mk(32'h0, 32'h0, 32'h0, 32'h10000, 32'h20001, 32'h0, 32'h0, 32'h10000,
                     1'b0, 2'd0, 33'h0, 68'h4_0004_0001, 5);
        vecs[6] = mk(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                     1'b1, 2'd2, 33'h0, 68'h0, 5);
        vecs[7] = mk(32'h7FFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h0, 32'h0, 32'hFFFFFFFF,
                     1'b1, 2'd1, 33'h0_FFFF_FFFF, 68'h0_FFFF_FFFE_0000_0001, 40);

        repeat (3) @(posedge clk);
        #1;
        chk("reset.in_ready", in_ready, 1'b1);
        chk("reset.out_valid", out_valid, 1'b0);
        chk("reset.busy", busy, 1'b0);
        chk("reset.ret", ret, 1'b0);
        chk("reset.cls", cls, 2'd0);
        chk("reset.depth", depth, 33'd0);
        chk("reset.dist2", dist2, 68'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("release.in_ready", in_ready, 1'b1);

        for (int unsigned i = 0; i < 8; i++)
            run_pair($sformatf("vec%0d", i), vecs[i], int'(i % 3));

        // Backpressure: result held, new pair waiting on in_valid must not enter early.
        present(vecs[1]);
        @(posedge clk); #1;
        present(vecs[0]);
        wait_valid("bp.first", 40);
        bad = 0;
        for (int unsigned k = 0; k < 20; k++) begin
            if (!out_valid || in_ready || ret !== vecs[1].ret || cls !== vecs[1].cls ||
                depth !== vecs[1].depth || dist2 !== vecs[1].dist2) bad++;
            @(posedge clk); #1;
        end
        chk("bp.stable_cycles", bad, 0);
        chk_out("bp.first", vecs[1]);
        chk("bp.in_ready_held", in_ready, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp.out_valid_drop", out_valid, 1'b0);
        chk("bp.in_ready_after_hs", in_ready, 1'b1);
`ifdef COLLIDE_SPHERES_FX_STATS_EN
        exp_tests++; exp_contacts++;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp.second_accepted", busy, 1'b1);
        wait_valid("bp.second", 5);
        chk_out("bp.second", vecs[0]);
        consume("bp.second", 1'b0);

        // Reset in the middle of the square-root phase.
        present(vecs[1]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        chk("rst_mid.busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_mid.out_valid", out_valid, 1'b0);
        chk("rst_mid.in_ready", in_ready, 1'b1);
        chk("rst_mid.busy", busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
`ifdef COLLIDE_SPHERES_FX_STATS_EN
        exp_tests = 0; exp_contacts = 0;
        chk("rst_mid.test_count", test_count, 0);
        chk("rst_mid.contact_count", contact_count, 0);
`endif
        @(posedge clk); #1;
        chk("rst_mid.out_valid_after", out_valid, 1'b0);
        run_pair("rst_mid.next", vecs[4], 0);

        for (int unsigned n = 0; n < 60; n++) begin
            int unsigned mode = $urandom_range(0, 3);
            for (int unsigned j = 0; j < 8; j++) begin
                if (mode == 0) c[j] = $urandom;
                else if (j == 3 || j == 7) c[j] = 32'($urandom_range(0, 32'h40000));
                else c[j] = 32'($urandom_range(0, 32'h80000)) - 32'h40000;
            end
            if (mode == 3) begin c[4] = c[0]; c[5] = c[1]; c[6] = c[2]; end
            v = model(c[0], c[1], c[2], c[3], c[4], c[5], c[6], c[7]);
            run_pair($sformatf("rnd%0d", n), v, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
